// File: rtl/uncache_arbiter.sv
// Shares one uncached bus port between instruction (m0) and data (m1) requesters; grant to bus_en is 1 cycle, done follows bus_reload by 1 cycle.
// Requesters stall until their own done; define UNCACHE_ARB_RR_EN for round-robin ties instead of fixed m1 priority.
module uncache_arbiter #(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 32
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               m0_en,
    input  logic [3:0]         m0_we,
    input  logic [ADDR_WD-1:0] m0_addr,
    input  logic [DATA_WD-1:0] m0_wdata,
    output logic               m0_stallreq,
    output logic               m0_done,
    output logic [DATA_WD-1:0] m0_rdata,

    input  logic               m1_en,
    input  logic [3:0]         m1_we,
    input  logic [ADDR_WD-1:0] m1_addr,
    input  logic [DATA_WD-1:0] m1_wdata,
    output logic               m1_stallreq,
    output logic               m1_done,
    output logic [DATA_WD-1:0] m1_rdata,

    output logic               bus_en,
    output logic [3:0]         bus_wsel,
    output logic [ADDR_WD-1:0] bus_addr,
    output logic [DATA_WD-1:0] bus_wdata,
    input  logic               bus_reload,
    input  logic [DATA_WD-1:0] bus_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        BUSY = 3'b010,
        RESP = 3'b100
    } state_t;

    state_t state, state_nxt;
    logic   owner;
    logic   grant;
    logic   grant_m1;
    logic   pick_m1;
    logic   capture;

`ifdef UNCACHE_ARB_RR_EN
    logic last;

    // On a tie, the port that was not granted last time wins.
    assign pick_m1 = m1_en & (~m0_en | ~last);
`else
    assign pick_m1 = m1_en;
`endif

    assign m0_stallreq = m0_en & ~((state == RESP) & (owner == 1'b0));
    assign m1_stallreq = m1_en & ~((state == RESP) & (owner == 1'b1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_m1  = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (m0_en | m1_en) begin
                    grant     = 1'b1;
                    grant_m1  = pick_m1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus_reload) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= 1'b0;
            bus_en    <= 1'b0;
            bus_wsel  <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            m0_done   <= 1'b0;
            m1_done   <= 1'b0;
`ifdef UNCACHE_ARB_RR_EN
            last      <= 1'b1;
`endif
        end else begin
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            if (grant) begin
                owner     <= grant_m1;
                bus_en    <= 1'b1;
                bus_wsel  <= grant_m1 ? m1_we    : m0_we;
                bus_addr  <= grant_m1 ? m1_addr  : m0_addr;
                bus_wdata <= grant_m1 ? m1_wdata : m0_wdata;
`ifdef UNCACHE_ARB_RR_EN
                last      <= grant_m1;
`endif
            end
            // Read data is captured for writes too; the owner just ignores it.
            if (capture) begin
                bus_en    <= 1'b0;
                bus_wsel  <= '0;
                bus_addr  <= '0;
                bus_wdata <= '0;
                if (owner) begin
                    m1_rdata <= bus_rdata;
                    m1_done  <= 1'b1;
                end else begin
                    m0_rdata <= bus_rdata;
                    m0_done  <= 1'b1;
                end
            end
        end
    end

endmodule
